// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// One word per line; misses and all writes go to main memory over a req/ack handshake.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              r_w,
  input  logic [31:0]       wdata,
  output logic              hit_miss,
  output logic [31:0]       data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_arr [LINES];
  logic [31:0]      data_arr [LINES];

  logic [INDEX_W-1:0] req_idx, fill_idx, arr_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               lookup_hit;
  logic               arr_we, tag_we, valid_set;
  logic [31:0]        arr_data;

  logic              hit_miss_d, mem_req_d, mem_we_d;
  logic [31:0]       data_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [CNT_W-1:0]  hit_cnt_d, miss_cnt_d;

  // Byte offset is irrelevant for whole-word accesses.
  logic addr_unused;
  assign addr_unused = &address[1:0];

  assign req_idx    = address[INDEX_W+1:2];
  assign req_tag    = address[ADDR_W-1:INDEX_W+2];
  // Refill uses the latched memory address, not the (ignored) live request.
  assign fill_idx   = mem_addr[INDEX_W+1:2];
  assign fill_tag   = mem_addr[ADDR_W-1:INDEX_W+2];
  assign lookup_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);

  always_comb begin
    state_nxt   = state;
    hit_miss_d  = hit_miss;
    data_d      = data;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    hit_cnt_d   = hit_count;
    miss_cnt_d  = miss_count;
    arr_we      = 1'b0;
    tag_we      = 1'b0;
    valid_set   = 1'b0;
    arr_idx     = req_idx;
    arr_data    = wdata;

    unique case (state)
      IDLE: begin
        if (!r_w && lookup_hit) begin
          hit_miss_d = 1'b0;
          data_d     = data_arr[req_idx];
          if (hit_count != '1) hit_cnt_d = hit_count + CNT_ONE;
        end else begin
          hit_miss_d = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = r_w;
          mem_addr_d = {address[ADDR_W-1:2], 2'b00};
          if (r_w) begin
            mem_wdata_d = wdata;
            arr_we      = lookup_hit;
            state_nxt   = WRITE;
          end else begin
            if (miss_count != '1) miss_cnt_d = miss_count + CNT_ONE;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_ack) begin
          arr_we     = 1'b1;
          tag_we     = 1'b1;
          valid_set  = 1'b1;
          arr_idx    = fill_idx;
          arr_data   = mem_rdata;
          data_d     = mem_rdata;
          hit_miss_d = 1'b0;
          mem_req_d  = 1'b0;
          state_nxt  = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          data_d     = mem_wdata;
          hit_miss_d = 1'b0;
          mem_req_d  = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      valid_q    <= '0;
      hit_miss   <= 1'b1;
      data       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= state_nxt;
      hit_miss   <= hit_miss_d;
      data       <= data_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      hit_count  <= hit_cnt_d;
      miss_count <= miss_cnt_d;
      if (valid_set) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (arr_we) data_arr[arr_idx] <= arr_data;
    if (tag_we) tag_arr[arr_idx]  <= fill_tag;
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: transaction-level reference model with
// per-cycle output comparison, plus directed requests with literal expectations.
module tb_dm_cache_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        r_w;
  logic [31:0] wdata;
  logic        hit_miss;
  logic [31:0] data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;
  logic cmp_on = 1'b0;

  dm_cache_ctrl #(.ADDR_W(32), .INDEX_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .r_w(r_w), .wdata(wdata),
    .hit_miss(hit_miss), .data(data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cache contents held as full word addresses per line;
  // a pending memory transaction is tracked as a single busy flag.
  logic [15:0] m_valid;
  logic [29:0] m_word [16];
  logic [31:0] m_data [16];
  logic        busy, busy_wr;
  logic        e_hit_miss, e_req, e_we;
  logic [31:0] e_data, e_addr, e_wdata;
  logic [15:0] e_hits, e_misses;

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[a[5:2]] && (m_word[a[5:2]] == a[31:2]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid    <= '0;
      busy       <= 1'b0;
      busy_wr    <= 1'b0;
      e_hit_miss <= 1'b1;
      e_data     <= '0;
      e_req      <= 1'b0;
      e_we       <= 1'b0;
      e_addr     <= '0;
      e_wdata    <= '0;
      e_hits     <= '0;
      e_misses   <= '0;
    end else if (!busy) begin
      if (!r_w && model_hit(address)) begin
        e_hit_miss <= 1'b0;
        e_data     <= m_data[address[5:2]];
        if (e_hits != 16'hFFFF) e_hits <= e_hits + 16'd1;
      end else begin
        e_hit_miss <= 1'b1;
        e_req      <= 1'b1;
        e_we       <= r_w;
        e_addr     <= {address[31:2], 2'b00};
        busy       <= 1'b1;
        busy_wr    <= r_w;
        if (r_w) begin
          e_wdata <= wdata;
          if (model_hit(address)) m_data[address[5:2]] <= wdata;
        end else if (e_misses != 16'hFFFF) begin
          e_misses <= e_misses + 16'd1;
        end
      end
    end else if (mem_ack) begin
      if (busy_wr) begin
        e_data <= e_wdata;
      end else begin
        m_valid[e_addr[5:2]] <= 1'b1;
        m_word[e_addr[5:2]]  <= e_addr[31:2];
        m_data[e_addr[5:2]]  <= mem_rdata;
        e_data               <= mem_rdata;
      end
      e_hit_miss <= 1'b0;
      e_req      <= 1'b0;
      busy       <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc/hit_miss",   32'(hit_miss),   32'(e_hit_miss));
      chk("cyc/data",       data,            e_data);
      chk("cyc/mem_req",    32'(mem_req),    32'(e_req));
      chk("cyc/mem_we",     32'(mem_we),     32'(e_we));
      chk("cyc/mem_addr",   mem_addr,        e_addr);
      chk("cyc/mem_wdata",  mem_wdata,       e_wdata);
      chk("cyc/hit_count",  32'(hit_count),  32'(e_hits));
      chk("cyc/miss_count", 32'(miss_count), 32'(e_misses));
    end
  end

  // Present one request starting before the next edge; ack d negedges after lookup.
  task automatic do_req(input string nm, input logic [31:0] a, input logic rw,
                        input logic [31:0] wd, input int d, input logic [31:0] rd,
                        input logic exp_busy, input logic [31:0] exp_data);
    int   n;
    logic done;
    address = a;
    r_w     = rw;
    wdata   = wd;
    @(posedge clk); #1;
    chk({nm, "/busy"}, 32'(hit_miss), 32'(exp_busy));
    if (hit_miss) begin
      chk({nm, "/mem_req"},  32'(mem_req), 32'd1);
      chk({nm, "/mem_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({nm, "/mem_we"},   32'(mem_we), 32'(rw));
      if (rw) chk({nm, "/mem_wdata"}, mem_wdata, wd);
      done = 1'b0;
      n    = 0;
      while (!done && n < 64) begin
        @(negedge clk);
        address = ~a;
        r_w     = ~rw;
        wdata   = ~wd;
        if (n == d) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        if (mem_ack) begin
          mem_ack = 1'b0;
          done    = 1'b1;
        end else begin
          chk({nm, "/wait"}, 32'(hit_miss), 32'd1);
        end
        n++;
      end
      if (!done) chk({nm, "/timeout"}, 32'd0, 32'd1);
    end
    chk({nm, "/done"}, 32'(hit_miss), 32'd0);
    chk({nm, "/data"}, data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    address   = 32'h0000_0010;
    r_w       = 1'b0;
    wdata     = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #3 reset = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset/hit_miss", 32'(hit_miss), 32'd1);
    chk("reset/data",     data, 32'd0);
    chk("reset/mem_req",  32'(mem_req), 32'd0);
    chk("reset/hits",     32'(hit_count), 32'd0);
    chk("reset/misses",   32'(miss_count), 32'd0);

    do_req("cold_rd",    32'h0000_0010, 1'b0, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    do_req("rehit",      32'h0000_0010, 1'b0, 32'h0, 0, 32'h0,         1'b0, 32'hDEAD_BEEF);
    chk("rehit/hits",   32'(hit_count),  32'd1);
    chk("rehit/misses", 32'(miss_count), 32'd1);
    do_req("conflict",   32'h0000_0050, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1, 32'h1234_5678);
    do_req("evicted",    32'h0000_0010, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    do_req("wr_hit",     32'h0000_0010, 1'b1, 32'hCAFE_F00D, 3, 32'h0, 1'b1, 32'hCAFE_F00D);
    do_req("rd_after_wr",32'h0000_0010, 1'b0, 32'h0, 0, 32'h0,         1'b0, 32'hCAFE_F00D);
    chk("rd_after_wr/mem_req", 32'(mem_req), 32'd0);
    do_req("wr_miss",    32'h0000_0090, 1'b1, 32'hA5A5_A5A5, 0, 32'h0, 1'b1, 32'hA5A5_A5A5);
    do_req("no_alloc",   32'h0000_0090, 1'b0, 32'h0, 1, 32'h5555_0090, 1'b1, 32'h5555_0090);
    do_req("top_miss",   32'hFFFF_FFFE, 1'b0, 32'h0, 0, 32'h0F0F_0F0F, 1'b1, 32'h0F0F_0F0F);
    do_req("top_hit",    32'hFFFF_FFFC, 1'b0, 32'h0, 0, 32'h0,         1'b1 ^ 1'b1, 32'h0F0F_0F0F);
    chk("mid/hits",   32'(hit_count),  32'd3);
    chk("mid/misses", 32'(miss_count), 32'd5);

    // Reset during a refill, with a stale ack left high across the release edge.
    address = 32'h0000_0030;
    r_w     = 1'b0;
    @(posedge clk); #1;
    chk("rstmid/busy", 32'(hit_miss), 32'd1);
    chk("rstmid/req",  32'(mem_req),  32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstmid/req_drop", 32'(mem_req),  32'd0);
    chk("rstmid/hm",       32'(hit_miss), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstmid/remiss", 32'(hit_miss), 32'd1);
    chk("rstmid/rereq",  32'(mem_req),  32'd1);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_0030;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstmid/fill", data, 32'h7777_0030);
    do_req("post_rst",   32'h0000_0010, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    do_req("post_hit",   32'h0000_0030, 1'b0, 32'h0, 0, 32'h0,         1'b0, 32'h7777_0030);
    chk("end/hits",   32'(hit_count),  32'd1);
    chk("end/misses", 32'(miss_count), 32'd2);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
